// File: rtl/rv32_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave).
interface rv32_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/rv32_fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, issues credit-limited word fetches
// and buffers in-order responses for the IF/ID register.
module rv32_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  rv32_fetch_unit_if.master   imem,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW:0] DepthW = (CntW + 1)'(FIFO_DEPTH);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    if (p == ptr_t'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + ptr_t'(1);
  endfunction

  logic [31:0] pc_q, pc_d;
  cnt_t        outst_q, outst_d;
  cnt_t        drop_q, drop_d;
  cnt_t        count_q, count_d;
  ptr_t        tag_wr_q, tag_wr_d;
  ptr_t        tag_rd_q, tag_rd_d;
  ptr_t        fifo_wr_q, fifo_wr_d;
  ptr_t        fifo_rd_q, fifo_rd_d;
  logic [31:0] tag_mem_q   [FIFO_DEPTH];
  logic [31:0] tag_mem_d   [FIFO_DEPTH];
  logic [31:0] pc_mem_q    [FIFO_DEPTH];
  logic [31:0] pc_mem_d    [FIFO_DEPTH];
  logic [31:0] instr_mem_q [FIFO_DEPTH];
  logic [31:0] instr_mem_d [FIFO_DEPTH];

  logic        deq;
  logic        req_hs;
  logic        rsp;
  logic        fifo_wr;
  logic [CntW:0] credit_used;

  // Low address bits of the redirect target are forced to zero.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign if_valid = (count_q != '0);
  assign if_pc    = if_valid ? pc_mem_q[fifo_rd_q] : 32'h0;
  assign if_instr = if_valid ? instr_mem_q[fifo_rd_q] : 32'h0;
  assign deq      = if_valid & ~stall;

  // Credits cover both buffered packets and requests still in flight, so a
  // non-dropped response always finds a free FIFO slot.
  assign credit_used = {1'b0, outst_q} + {1'b0, count_q} - {{CntW{1'b0}}, deq};

  assign imem.imem_req_valid = resetn & (credit_used < DepthW);
  assign imem.imem_req_addr  = pc_q;

  assign req_hs = imem.imem_req_valid & imem.imem_req_ready;
  assign rsp    = imem.imem_rsp_valid;

  always_comb begin
    pc_d        = pc_q;
    outst_d     = outst_q;
    drop_d      = drop_q;
    count_d     = count_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    tag_mem_d   = tag_mem_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    fifo_wr     = 1'b0;

    // Tag queue tracks every accepted request, stale or not, and pops on
    // every response so tags stay aligned with the in-order return stream.
    if (req_hs) begin
      pc_d                = pc_q + 32'd4;
      tag_mem_d[tag_wr_q] = pc_q;
      tag_wr_d            = ptr_inc(tag_wr_q);
    end
    if (rsp) begin
      tag_rd_d = ptr_inc(tag_rd_q);
    end
    outst_d = outst_q + cnt_t'(req_hs) - cnt_t'(rsp);

    if (redirect_valid) begin
      pc_d      = {redirect_pc[31:2], 2'b00};
      count_d   = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      drop_d    = outst_d;
    end else begin
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - cnt_t'(1);
        end else begin
          fifo_wr = 1'b1;
        end
      end
      if (fifo_wr) begin
        pc_mem_d[fifo_wr_q]    = tag_mem_q[tag_rd_q];
        instr_mem_d[fifo_wr_q] = imem.imem_rsp_data;
        fifo_wr_d              = ptr_inc(fifo_wr_q);
      end
      if (deq) begin
        fifo_rd_d = ptr_inc(fifo_rd_q);
      end
      count_d = count_q + cnt_t'(fifo_wr) - cnt_t'(deq);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= RESET_PC;
      outst_q     <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      tag_mem_q   <= '{default: '0};
      pc_mem_q    <= '{default: '0};
      instr_mem_q <= '{default: '0};
    end else begin
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      tag_mem_q   <= tag_mem_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(fifo_wr && (count_q == cnt_t'(FIFO_DEPTH)) && !deq));

  a_no_rsp_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(rsp && (outst_q == '0)));

  a_addr_stable: assert property (@(posedge clk) disable iff (!resetn)
    (imem.imem_req_valid && !imem.imem_req_ready && !redirect_valid)
      |=> $stable(imem.imem_req_addr));

endmodule
